// File: rtl/uart_receiver.sv
// 8N1 serial receiver: synchronises rx, recovers start/data/stop bits by mid-bit
// sampling, and delivers each good byte as a single-cycle char_data/char_ready strobe.
module uart_receiver #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int BAUD_RATE       = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] char_data,
  output logic       char_ready,
  output logic       framing_error,
  output logic       busy
);

  localparam int CLOCKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int HALF_BIT       = CLOCKS_PER_BIT / 2;
  localparam int CNT_W          = $clog2(CLOCKS_PER_BIT);

  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  // Below four clocks per bit the half-bit start check has no room to reject glitches.
  if (CLOCKS_PER_BIT < 4) begin : g_bad_rate
    $error("uart_receiver: CLOCK_FREQUENCY / BAUD_RATE must be at least 4");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             rx_sync1;
  logic             rx_sync;
  logic [CNT_W-1:0] bit_counter;
  logic [2:0]       bit_index;
  logic [7:0]       shift;
  logic             at_half;
  logic             at_full;

  assign at_half = (bit_counter == HALF_LAST);
  assign at_full = (bit_counter == FULL_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_sync1 <= 1'b1;
      rx_sync  <= 1'b1;
    end else begin
      rx_sync1 <= rx;
      rx_sync  <= rx_sync1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!rx_sync) state_next = START;
      START:     if (at_half) state_next = rx_sync ? IDLE : DATA;
      DATA:      if (at_full && (bit_index == 3'd7)) state_next = STOP;
      STOP:      if (at_full) state_next = rx_sync ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_sync) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    if (state != IDLE) busy = 1'b1;
  end

  // Bit timing, shift register and the registered byte/strobe outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_counter   <= '0;
      bit_index     <= 3'd0;
      shift         <= 8'h00;
      char_data     <= 8'h00;
      char_ready    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      char_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_sync) bit_counter <= '0;
        end
        START: begin
          if (at_half) begin
            bit_counter <= '0;
            bit_index   <= 3'd0;
          end else begin
            bit_counter <= bit_counter + 1'b1;
          end
        end
        DATA: begin
          if (at_full) begin
            shift       <= {rx_sync, shift[7:1]};
            bit_counter <= '0;
            bit_index   <= bit_index + 3'd1;
          end else begin
            bit_counter <= bit_counter + 1'b1;
          end
        end
        STOP: begin
          if (at_full) begin
            bit_counter <= '0;
            if (rx_sync) begin
              char_data  <= shift;
              char_ready <= 1'b1;
            end else begin
              framing_error <= 1'b1;
            end
          end else begin
            bit_counter <= bit_counter + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: frames are pushed to a scoreboard as they are driven,
// and a negedge monitor pops and compares byte and arrival cycle on every char_ready.
module tb_uart_receiver;

  localparam int CPB  = 16;
  localparam int HB   = CPB / 2;
  localparam int CPB2 = 50000000 / 115200;
  localparam int HB2  = CPB2 / 2;

  typedef struct {
    logic [7:0] b;
    int         c;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rx    = 1'b1;
  logic       rx2   = 1'b1;
  logic [7:0] char_data, char_data2;
  logic       char_ready, framing_error, busy;
  logic       char_ready2, framing_error2, busy2;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t q[$];
  exp_t e;
  int   got2 = 0;
  int   c2 = 0;
  logic [7:0] d2 = 8'h00;

  uart_receiver #(.CLOCK_FREQUENCY(16), .BAUD_RATE(1)) dut (
    .clock(clock), .reset(reset), .rx(rx), .char_data(char_data),
    .char_ready(char_ready), .framing_error(framing_error), .busy(busy)
  );

  uart_receiver dut2 (
    .clock(clock), .reset(reset), .rx(rx2), .char_data(char_data2),
    .char_ready(char_ready2), .framing_error(framing_error2), .busy(busy2)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endfunction

  // Scoreboard monitor: byte value and arrival cycle must match the model.
  always @(negedge clock) begin
    if (char_ready) begin
      if (q.size() == 0) begin
        check("unexpected_char_ready", 1, 0);
      end else begin
        e = q.pop_front();
        check("char_data", int'(char_data), int'(e.b));
        check("char_ready_cycle", cyc, e.c);
      end
    end
  end

  always @(negedge clock) begin
    if (char_ready2) begin
      got2++;
      d2 = char_data2;
      c2 = cyc;
    end
  end

  // All line-driving tasks start and end 1 time unit after a rising edge.
  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    hold(1'b1, n);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit expect_it,
                            input logic stop_v, input int stop_len);
    exp_t x;
    if (expect_it) begin
      x.b = b;
      x.c = cyc + 2 + HB + 9 * CPB + 1;
      q.push_back(x);
    end
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop_v, stop_len * CPB);
  endtask

  task automatic send2(input logic [7:0] b);
    rx2 = 1'b0;
    repeat (CPB2) @(posedge clock);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx2 = b[i];
      repeat (CPB2) @(posedge clock);
      #1;
    end
    rx2 = 1'b1;
    repeat (CPB2) @(posedge clock);
    #1;
  endtask

  task automatic wait_cyc_neg(input int t);
    do @(negedge clock); while (cyc < t);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 4000 && q.size() != 0; i++) @(negedge clock);
    check("scoreboard_drained", q.size(), 0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int fall;
    int fall2;
    logic [7:0] msg [4];
    msg[0] = 8'h53; msg[1] = 8'h33; msg[2] = 8'h0D; msg[3] = 8'h0A;

    #3 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_char_data", int'(char_data), 0);
    check("reset_char_ready", int'(char_ready), 0);
    check("reset_framing_error", int'(framing_error), 0);
    check("reset_busy", int'(busy), 0);
    reset = 1'b0;
    idle(500);
    check("idle_busy", int'(busy), 0);

    send_frame(8'h53, 1'b1, 1'b1, 1);
    idle(CPB);
    wait_drain();
    check("single_framing_error", int'(framing_error), 0);

    for (int i = 0; i < 4; i++) send_frame(msg[i], 1'b1, 1'b1, 1);
    wait_drain();
    idle(4);
    check("b2b_busy_after", int'(busy), 0);

    fall = cyc;
    hold(1'b0, 4);
    rx = 1'b1;
    wait_cyc_neg(fall + 3 + 7);
    check("glitch_busy_before", int'(busy), 1);
    wait_cyc_neg(fall + 3 + 8);
    check("glitch_busy_after", int'(busy), 0);
    @(posedge clock);
    #1;
    idle(2 * CPB);
    check("glitch_framing_error", int'(framing_error), 0);

    fall = cyc;
    fork
      send_frame(8'hA5, 1'b0, 1'b0, 40);
      begin
        wait_cyc_neg(fall + 2 + HB + 9 * CPB);
        check("fe_before_stop", int'(framing_error), 0);
        wait_cyc_neg(fall + 3 + HB + 9 * CPB);
        check("fe_after_stop", int'(framing_error), 1);
        check("fe_char_data_kept", int'(char_data), 8'h0A);
      end
    join
    idle(2 * CPB);
    check("break_busy_released", int'(busy), 0);
    send_frame(8'h31, 1'b1, 1'b1, 1);
    wait_drain();
    check("fe_sticky", int'(framing_error), 1);

    fall = cyc;
    fork
      send_frame(8'hFF, 1'b0, 1'b1, 1);
      begin
        wait_cyc_neg(fall + 4 * CPB + 8);
        reset = 1'b1;
        wait_cyc_neg(fall + 4 * CPB + 11);
        check("midreset_char_ready", int'(char_ready), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_fe_cleared", int'(framing_error), 0);
        check("midreset_char_data", int'(char_data), 0);
        reset = 1'b0;
      end
    join
    idle(CPB);
    send_frame(8'h0A, 1'b1, 1'b1, 1);
    wait_drain();

    for (int i = 0; i < 20; i++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1, 1);
      idle($urandom_range(0, 20));
    end
    wait_drain();
    check("random_framing_error", int'(framing_error), 0);

    fall2 = cyc;
    send2(8'h53);
    repeat (10) @(posedge clock);
    #1;
    check("default_count", got2, 1);
    check("default_char_data", int'(d2), 8'h53);
    check("default_cycle", c2, fall2 + 2 + HB2 + 9 * CPB2 + 1);
    check("default_framing_error", int'(framing_error2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
